// File: rtl/quarter_sine_sample_gen.sv
// quarter_sine_sample_gen: sample-rate divider + phase accumulator that reads a
// quarter-wave magnitude ROM and folds it back into a full unsigned sine sample.
module quarter_sine_sample_gen #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 11,
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 13,
  parameter int RD_LAT  = 1
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               enable,
  input  logic [DIV_W-1:0]   tick_div,
  input  logic [PHASE_W-1:0] tuning_word,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-2:0]  rom_data,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  output logic               phase_wrap
);

  // tick -> rom_en is one stage, then RD_LAT stages of BRAM read
  localparam int STAGES = RD_LAT + 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic                en_q;
  logic [DIV_W-1:0]    cnt;
  logic                tick;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W:0]    sum;
  logic [PHASE_W-1:0]  pn;
  logic [1:0]          q;
  logic [ADDR_W-1:0]   idx;
  logic [STAGES:1]     vld_pipe;
  logic [STAGES:1]     sgn_pipe;

  // Reset asserts immediately, releases two clocks after CPU_RESETN rises
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign tick = en_q && (cnt >= tick_div);

  // Divider: registered enable, count up, wrap to 0 on tick; held at 0 when idle
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      cnt  <= '0;
    end else begin
      en_q <= enable;
      if (!en_q || tick) cnt <= '0;
      else               cnt <= cnt + DIV_W'(1);
    end
  end

  assign sum = {1'b0, phase} + {1'b0, tuning_word};
  assign pn  = sum[PHASE_W-1:0];
  assign q   = pn[PHASE_W-1 -: 2];
  assign idx = pn[PHASE_W-3 -: ADDR_W];

  // Phase step and ROM address on each tick; odd quadrants walk the table backwards
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      phase_wrap <= 1'b0;
      rom_addr   <= '0;
    end else begin
      phase_wrap <= tick && sum[PHASE_W];
      if (tick) begin
        phase    <= pn;
        rom_addr <= q[0] ? ~idx : idx;
      end
    end
  end

  // Valid and sign travel alongside the BRAM read
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sgn_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], tick};
      sgn_pipe <= {sgn_pipe[STAGES-1:1], q[1]};
    end
  end
  assign rom_en = vld_pipe[1];

  // Fold magnitude around mid-scale: MID+mag is {1,mag}, MID-1-mag is {0,~mag}
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      sample_out   <= MID;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES])
        sample_out <= sgn_pipe[STAGES] ? {1'b0, ~rom_data} : {1'b1, rom_data};
    end
  end

endmodule

// File: tb/tb_quarter_sine_sample_gen.sv
// Bench for quarter_sine_sample_gen: two instances (RD_LAT=1 and 2) on shared
// stimulus, each checked every cycle against a cycle-indexed event model.
module tb_quarter_sine_sample_gen;

  logic        clk = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        enable = 1'b0;
  logic [12:0] tick_div = 13'd4;
  logic [23:0] tuning_word = 24'h400000;

  logic        rom_en1, rom_en2, vld1, vld2, wrap1, wrap2;
  logic [7:0]  rom_addr1, rom_addr2;
  logic [9:0]  rd1 = '0, r2a = '0, rd2 = '0;
  logic [10:0] smp1, smp2;

  always #5 clk = ~clk;

  quarter_sine_sample_gen #(.RD_LAT(1)) u1 (
    .CLK100MHZ(clk), .CPU_RESETN(CPU_RESETN), .enable(enable), .tick_div(tick_div),
    .tuning_word(tuning_word), .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rd1),
    .sample_out(smp1), .sample_valid(vld1), .phase_wrap(wrap1));

  quarter_sine_sample_gen #(.RD_LAT(2)) u2 (
    .CLK100MHZ(clk), .CPU_RESETN(CPU_RESETN), .enable(enable), .tick_div(tick_div),
    .tuning_word(tuning_word), .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rd2),
    .sample_out(smp2), .sample_valid(vld2), .phase_wrap(wrap2));

  // Quarter-wave table contents: magnitude = 4*addr
  function automatic logic [9:0] mag_f(input logic [7:0] a);
    return {a, 2'b00};
  endfunction

  // BRAM models with 1 and 2 cycle read latency
  always @(posedge clk) begin
    if (rom_en1) rd1 <= mag_f(rom_addr1);
    if (rom_en2) r2a <= mag_f(rom_addr2);
    rd2 <= r2a;
  end

  int errors = 0, checks = 0;
  bit chk_on = 0;
  bit log_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  // Model state: scheduled future events keyed by cycle number
  int cyc = 0;
  int sync_n = 0;
  int ev_rom[int], ev_wrap[int], ev_s1[int], ev_s2[int];
  int e_addr = 0, e_s1 = 1024, e_s2 = 1024;
  longint m_phase = 0;
  int m_cnt = 0;
  bit m_en = 0, prev_enable = 0;
  int ren1_q[$], addr1_q[$], vc1_q[$], s1_q[$], ren2_q[$], vc2_q[$], s2_q[$], wrap_q[$];
  int en_rise = -1;

  // Per-cycle: apply reset, compare outputs, then advance the model one cycle
  always @(negedge clk) begin
    bit in_rst, er, ew, e1, e2;
    cyc++;
    if (!CPU_RESETN) sync_n = 0;
    in_rst = !CPU_RESETN || sync_n < 2;
    if (CPU_RESETN && sync_n < 2) sync_n++;
    if (in_rst) begin
      ev_rom.delete(); ev_wrap.delete(); ev_s1.delete(); ev_s2.delete();
      e_addr = 0; e_s1 = 1024; e_s2 = 1024;
      m_phase = 0; m_cnt = 0; m_en = 0;
    end
    er = ev_rom.exists(cyc);  if (er) e_addr = ev_rom[cyc];
    ew = ev_wrap.exists(cyc);
    e1 = ev_s1.exists(cyc);   if (e1) e_s1 = ev_s1[cyc];
    e2 = ev_s2.exists(cyc);   if (e2) e_s2 = ev_s2[cyc];
    if (chk_on) begin
      chk("rom_en1", rom_en1, er);   chk("rom_en2", rom_en2, er);
      chk("rom_addr1", rom_addr1, e_addr); chk("rom_addr2", rom_addr2, e_addr);
      chk("wrap1", wrap1, ew);       chk("wrap2", wrap2, ew);
      chk("valid1", vld1, e1);       chk("valid2", vld2, e2);
      chk("sample1", smp1, e_s1);    chk("sample2", smp2, e_s2);
    end
    if (log_on) begin
      if (rom_en1) begin ren1_q.push_back(cyc); addr1_q.push_back(rom_addr1); end
      if (rom_en2) ren2_q.push_back(cyc);
      if (vld1) begin vc1_q.push_back(cyc); s1_q.push_back(smp1); end
      if (vld2) begin vc2_q.push_back(cyc); s2_q.push_back(smp2); end
      if (wrap1) wrap_q.push_back(cyc);
      if (enable && !prev_enable && en_rise < 0) en_rise = cyc;
    end
    prev_enable = enable;
    if (!in_rst) begin
      if (m_en && m_cnt >= tick_div) begin
        longint s;
        int pn, quad, idx, addr, mag, samp;
        s    = m_phase + longint'(tuning_word);
        pn   = int'(s % 64'd16777216);
        quad = pn / 4194304;
        idx  = (pn / 16384) % 256;
        addr = (quad % 2 == 1) ? 255 - idx : idx;
        mag  = 4 * addr;
        samp = (quad < 2) ? 1024 + mag : 1023 - mag;
        ev_rom[cyc+1] = addr;
        if (s >= 64'd16777216) ev_wrap[cyc+1] = 1;
        ev_s1[cyc+3] = samp;
        ev_s2[cyc+4] = samp;
        m_phase = pn;
        m_cnt = 0;
      end else if (m_en) m_cnt++;
      else m_cnt = 0;
      m_en = enable;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    ren1_q.delete(); addr1_q.delete(); vc1_q.delete(); s1_q.delete();
    ren2_q.delete(); vc2_q.delete(); s2_q.delete(); wrap_q.delete();
    en_rise = -1;
  endtask

  initial begin
    bit seen;
    step(4);
    chk_on = 1;
    chk("reset_sample", smp1, 1024);
    chk("reset_valid", vld1, 0);
    CPU_RESETN = 1;
    step(5);

    // Quarter-step tone: ticks every 5 cycles, one step per quadrant
    tick_div = 13'd4; tuning_word = 24'h400000;
    clr_logs(); log_on = 1;
    enable = 1;
    step(30);
    enable = 0;
    step(8);
    chk("t2_addr0", addr1_q[0], 255); chk("t2_addr1", addr1_q[1], 0);
    chk("t2_addr2", addr1_q[2], 255); chk("t2_addr3", addr1_q[3], 0);
    chk("t2_s0", s1_q[0], 2044); chk("t2_s1", s1_q[1], 1023);
    chk("t2_s2", s1_q[2], 3);    chk("t2_s3", s1_q[3], 1024);
    chk("t2_lat2_s0", s2_q[0], 2044); chk("t2_lat2_s2", s2_q[2], 3);
    chk("t2_period", ren1_q[1] - ren1_q[0], 5);
    chk("t2_wrap_4th", wrap_q[0], ren1_q[3]);
    chk("t2_lat_rd1", vc1_q[0] - ren1_q[0], 2);
    chk("t2_lat_rd2", vc2_q[0] - ren2_q[0], 3);

    // Hold for 20 cycles, then re-enable with tick_div=9
    tick_div = 13'd9; tuning_word = 24'h123456;
    step(20);
    clr_logs();
    enable = 1;
    step(20);
    chk("t4_first_valid", vc1_q[0] - en_rise, 13);

    // Lower tick_div from 9 to 3 while cnt=7
    clr_logs();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = rom_en1;
    end
    chk("t6_wait_rom_en", seen, 1);
    step(7);
    tick_div = 13'd3;
    step(16);
    chk("t6_gap0", ren1_q[1] - ren1_q[0], 8);
    chk("t6_gap1", ren1_q[2] - ren1_q[1], 4);
    chk("t6_gap2", ren1_q[3] - ren1_q[2], 4);

    // Change tuning 2 cycles after a tick (model checks the step sizes)
    step(3);
    tuning_word = 24'h0A0000;
    step(12);

    // Reset mid-pipeline with tick every cycle, then sweep through a quadrant
    tick_div = 13'd0; tuning_word = 24'h010000;
    step(6);
    CPU_RESETN = 0;
    @(negedge clk);
    chk("t1_rst_sample", smp1, 1024);
    chk("t1_rst_valid", vld1, 0);
    chk("t1_rst_rom_en", rom_en1, 0);
    step(2);
    clr_logs();
    CPU_RESETN = 1;
    step(75);
    chk("t3_addr0", addr1_q[0], 4);
    chk("t3_addr1", addr1_q[1], 8);
    chk("t3_addr2", addr1_q[2], 12);
    chk("t3_addr62", addr1_q[62], 252);
    chk("t3_addr63", addr1_q[63], 255);
    chk("t3_addr64", addr1_q[64], 251);
    chk("t3_every_cycle", vc1_q[10] - vc1_q[0], 10);

    // Randomized run with occasional resets
    log_on = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) tick_div = 13'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) tuning_word = 24'($urandom());
      if ($urandom_range(0, 149) == 0) begin
        CPU_RESETN = 0;
        step($urandom_range(1, 3));
        CPU_RESETN = 1;
      end
      step(1);
    end
    enable = 0;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
